// File: rtl/cache_ctrl_pkg.sv
// Shared geometry and FSM encoding for the direct-mapped write-through cache controller.
package cache_defs;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_INDEX_W  = 8;
    localparam int DEF_OFFSET_W = 4;
    localparam int DEF_TAG_W    = DEF_ADDR_W - DEF_INDEX_W - DEF_OFFSET_W;
    localparam int N_BANKS      = 4;
    localparam int LINE_W       = 32 * N_BANKS;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOOKUP   = 3'd1;
    localparam logic [2:0] S_MISS_REQ = 3'd2;
    localparam logic [2:0] S_REFILL   = 3'd3;
    localparam logic [2:0] S_RESP     = 3'd4;
    localparam logic [2:0] S_WR_MEM   = 3'd5;

    // Pick one 32-bit bank word out of a full line.
    function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line,
                                              input logic [1:0] sel);
        return line[{sel, 5'b0} +: 32];
    endfunction

endpackage

// File: rtl/cache_ctrl_tag_valid.sv
// Tag and valid store: one write port, combinational read, valid bits cleared by reset or flush.
module tag_valid #(
    parameter int INDEX_W = 8,
    parameter int TAG_W   = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic [INDEX_W-1:0] rd_index_i,
    input  logic               wr_en_i,
    input  logic [INDEX_W-1:0] wr_index_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    output logic               rd_valid_o,
    output logic [TAG_W-1:0]   rd_tag_o
);

    localparam int N_SETS = 1 << INDEX_W;

    logic [N_SETS-1:0] valid_q;
    logic [TAG_W-1:0]  tag_q [N_SETS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    // Tags need no reset: a set is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_index_i] <= wr_tag_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, read-allocate cache controller: tag/valid store plus
// the lookup / refill / write-through FSM in front of an external 4-bank data array.
module cache_ctrl
    import cache_defs::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int INDEX_W  = DEF_INDEX_W,
    parameter int OFFSET_W = DEF_OFFSET_W,
    parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_req_i,
    input  logic                cpu_we_i,
    input  logic [3:0]          cpu_be_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [31:0]         cpu_wdata_i,
    output logic                cpu_ready_o,
    output logic                cpu_rvalid_o,
    output logic [31:0]         cpu_rdata_o,
    input  logic                flush_i,
    output logic [INDEX_W-1:0]  arr_index_o,
    output logic [OFFSET_W-1:0] arr_offset_o,
    output logic [3:0]          arr_wr_en_o,
    output logic [LINE_W-1:0]   arr_wr_data_o,
    input  logic [LINE_W-1:0]   arr_rd_data_i,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [31:0]         mem_wdata_o,
    output logic [3:0]          mem_be_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [31:0]         mem_rdata_i,
    output logic [2:0]          dbg_state_o
);

    // Handshakes: a CPU request transfers on cpu_req_i & cpu_ready_o (request held until
    // then); a memory request transfers on mem_req_o & mem_gnt_i; cpu_rvalid_o and
    // mem_rvalid_i are single-cycle pulses with no back-pressure.

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [1:0]        beat_q;

    logic [INDEX_W-1:0] idx_q;
    logic [TAG_W-1:0]   tag_in;
    logic               tv_valid;
    logic [TAG_W-1:0]   tv_tag;
    logic               accept;
    logic               hit;
    logic               refill_beat;
    logic               refill_last;

    assign idx_q       = addr_q[OFFSET_W +: INDEX_W];
    assign tag_in      = addr_q[ADDR_W-1 -: TAG_W];
    assign accept      = (state_q == S_IDLE) && cpu_req_i && !flush_i;
    assign hit         = tv_valid && (tv_tag == tag_in);
    assign refill_beat = (state_q == S_REFILL) && mem_rvalid_i;
    assign refill_last = refill_beat && (beat_q == 2'd3);
    assign dbg_state_o = state_q;

    tag_valid #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_tag_valid (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    ((state_q == S_IDLE) && flush_i),
        .rd_index_i (idx_q),
        .wr_en_i    (refill_last),
        .wr_index_i (idx_q),
        .wr_tag_i   (tag_in),
        .rd_valid_o (tv_valid),
        .rd_tag_o   (tv_tag)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (accept) state_d = S_LOOKUP;
            S_LOOKUP: begin
                if (we_q)     state_d = S_WR_MEM;
                else if (hit) state_d = S_IDLE;
                else          state_d = S_MISS_REQ;
            end
            S_MISS_REQ: if (mem_gnt_i) state_d = S_REFILL;
            S_REFILL:   if (refill_last) state_d = S_RESP;
            S_RESP:     state_d = S_IDLE;
            S_WR_MEM:   if (mem_gnt_i) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= cpu_addr_i;
                we_q    <= cpu_we_i;
                be_q    <= cpu_be_i;
                wdata_q <= cpu_wdata_i;
            end
            if (state_q == S_MISS_REQ) begin
                beat_q <= '0;
            end else if (refill_beat) begin
                beat_q <= beat_q + 2'd1;
                if (beat_q == addr_q[3:2]) rdata_q <= mem_rdata_i;
            end
        end
    end

    // The array read is issued from the live address on accept so data lands in LOOKUP.
    always_comb begin
        cpu_ready_o   = accept;
        cpu_rvalid_o  = 1'b0;
        cpu_rdata_o   = '0;
        arr_index_o   = accept ? cpu_addr_i[OFFSET_W +: INDEX_W] : idx_q;
        arr_offset_o  = accept ? cpu_addr_i[OFFSET_W-1:0] : addr_q[OFFSET_W-1:0];
        arr_wr_en_o   = '0;
        arr_wr_data_o = '0;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        mem_be_o      = '0;
        case (state_q)
            S_LOOKUP: begin
                if (hit && we_q) begin
                    arr_wr_en_o   = be_q;
                    arr_wr_data_o = {N_BANKS{wdata_q}};
                end else if (hit) begin
                    cpu_rvalid_o = 1'b1;
                    cpu_rdata_o  = line_word(arr_rd_data_i, addr_q[3:2]);
                end
            end
            S_MISS_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            end
            S_REFILL: begin
                arr_offset_o = {beat_q, 2'b00};
                if (mem_rvalid_i) begin
                    arr_wr_en_o   = 4'hF;
                    arr_wr_data_o = {N_BANKS{mem_rdata_i}};
                end
            end
            S_RESP: begin
                cpu_rvalid_o = 1'b1;
                cpu_rdata_o  = rdata_q;
            end
            S_WR_MEM: begin
                mem_req_o    = 1'b1;
                mem_we_o     = 1'b1;
                mem_addr_o   = addr_q;
                mem_be_o     = be_q;
                mem_wdata_o  = wdata_q;
                cpu_rvalid_o = mem_gnt_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Randomised bench for cache_ctrl: data-array and memory models, cache reference model and scoreboard.
module tb_cache_ctrl;
    import cache_defs::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cpu_req_i, cpu_we_i, flush_i;
    logic [3:0]   cpu_be_i;
    logic [31:0]  cpu_addr_i, cpu_wdata_i;
    logic         cpu_ready_o, cpu_rvalid_o;
    logic [31:0]  cpu_rdata_o;
    logic [7:0]   arr_index_o;
    logic [3:0]   arr_offset_o, arr_wr_en_o;
    logic [127:0] arr_wr_data_o;
    logic [127:0] arr_rd_data_i = '0;
    logic         mem_req_o, mem_we_o;
    logic [31:0]  mem_addr_o, mem_wdata_o;
    logic [3:0]   mem_be_o;
    logic         mem_gnt_i, mem_rvalid_i;
    logic [31:0]  mem_rdata_i;
    logic [2:0]   dbg_state_o;

    cache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_be_i(cpu_be_i),
        .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
        .cpu_ready_o(cpu_ready_o), .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o),
        .flush_i(flush_i),
        .arr_index_o(arr_index_o), .arr_offset_o(arr_offset_o), .arr_wr_en_o(arr_wr_en_o),
        .arr_wr_data_o(arr_wr_data_o), .arr_rd_data_i(arr_rd_data_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass = 0;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    typedef struct {
        logic [31:0] rdata;
        bit          is_load;
        bit          miss;
        int          refills;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    // ---------------- reference models ----------------
    logic [31:0] mem_model [logic [29:0]];
    bit          valid_m [256];
    logic [19:0] tag_m [256];
    logic [31:0] cur_addr, cur_wd;
    logic [3:0]  cur_be;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_model.exists(a[31:2])) return mem_model[a[31:2]];
        return {a[31:2], 2'b00} ^ {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    function automatic void clear_valid();
        for (int i = 0; i < 256; i++) valid_m[i] = 1'b0;
    endfunction

    // Synchronous data array: read-old-data, byte writes within the bank chosen by offset[3:2].
    logic [31:0] arr_mem [256][4];
    always @(posedge clk) begin : arr_model
        logic [31:0] w;
        w = arr_mem[arr_index_o][arr_offset_o[3:2]];
        for (int b = 0; b < 4; b++)
            if (arr_wr_en_o[b]) w[8*b +: 8] = arr_wr_data_o[32*arr_offset_o[3:2] + 8*b +: 8];
        if (arr_wr_en_o != 4'h0) arr_mem[arr_index_o][arr_offset_o[3:2]] <= w;
        arr_rd_data_i <= {arr_mem[arr_index_o][3], arr_mem[arr_index_o][2],
                          arr_mem[arr_index_o][1], arr_mem[arr_index_o][0]};
    end

    // ---------------- memory responder ----------------
    int beats_left = 0;
    int beat_n = 0;
    int refill_count = 0;
    logic [31:0] line_addr = '0;

    initial begin : responder
        logic [31:0] w;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = $urandom();
            if (!rst_n) begin
                beats_left = 0;
            end else if (beats_left > 0) begin
                if ($urandom_range(0, 3) != 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = mem_word(line_addr + 32'(4 * beat_n));
                    beat_n++;
                    beats_left--;
                end
            end else if (mem_req_o && $urandom_range(0, 2) != 0) begin
                mem_gnt_i = 1'b1;
                if (mem_we_o) begin
                    check("mem_write", {mem_addr_o, mem_be_o, mem_wdata_o}, {cur_addr, cur_be, cur_wd});
                    w = mem_word(mem_addr_o);
                    for (int b = 0; b < 4; b++) if (mem_be_o[b]) w[8*b +: 8] = mem_wdata_o[8*b +: 8];
                    mem_model[mem_addr_o[31:2]] = w;
                end else begin
                    check("mem_read_addr", mem_addr_o, {cur_addr[31:4], 4'b0});
                    line_addr = mem_addr_o; beats_left = 4; beat_n = 0; refill_count++;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                mem_rvalid_i = 1'b1;    // stray beat outside a refill
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && cpu_rvalid_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_rvalid: got rdata %0h with no request outstanding", cpu_rdata_o);
                end else begin
                    e = exp_q.pop_front();
                    check(e.is_load ? "load_rdata" : "store_ack_rdata", cpu_rdata_o, e.rdata);
                    check("refill_count", refill_count - e.refills, e.miss ? 1 : 0);
                    if (e.is_load && !e.miss) check("hit_latency", cyc - e.cyc, 1);
                    if (e.miss) check("miss_latency_min", (cyc - e.cyc) >= 7, 1);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input bit we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        int waited = 0;
        logic [7:0] idx;
        bit hit;
        @(negedge clk);
        cpu_req_i = 1'b1; cpu_we_i = we; cpu_be_i = be; cpu_addr_i = addr; cpu_wdata_i = wd;
        #1;
        while (!cpu_ready_o) begin
            if (waited > 300) begin
                n_checks++;
                $display("FAIL ready_timeout: got no accept for addr %0h within 300 cycles", addr);
                cpu_req_i = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
            waited++;
        end
        idx = addr[11:4];
        hit = valid_m[idx] && (tag_m[idx] == addr[31:12]);
        e.is_load = !we;
        e.miss    = !we && !hit;
        e.rdata   = we ? 32'h0 : mem_word(addr);
        e.refills = refill_count;
        e.cyc     = cyc;
        if (e.miss) begin valid_m[idx] = 1'b1; tag_m[idx] = addr[31:12]; end
        cur_addr = addr; cur_be = be; cur_wd = wd;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_be_i = '0; cpu_addr_i = '0; cpu_wdata_i = '0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 0 && dbg_state_o == S_IDLE) return;
        end
        n_checks++;
        $display("FAIL idle_timeout: got state %0d with %0d responses pending", dbg_state_o, exp_q.size());
    endtask

    task automatic do_flush();
        wait_idle();
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        clear_valid();
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {cpu_ready_o, cpu_rvalid_o, cpu_rdata_o, arr_index_o, arr_offset_o, arr_wr_en_o,
                     mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o}, '0);
        check({name, "_arr_wdata"}, arr_wr_data_o, '0);
    endtask

    initial begin : watchdog
        #600000;
        n_checks++;
        $display("FAIL global_timeout: got simulation still running, expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int waited;
        for (int i = 0; i < 256; i++)
            for (int b = 0; b < 4; b++) arr_mem[i][b] = $urandom();
        clear_valid();
        cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_be_i = '0; cpu_addr_i = '0; cpu_wdata_i = '0; flush_i = 1'b0;
        #3;
        check_outputs_zero("reset_outputs");
        check("reset_state", dbg_state_o, S_IDLE);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        issue(1'b0, 4'h0, 32'h0000_1234, 32'h0);          // cold miss, returns A1
        issue(1'b0, 4'h0, 32'h0000_1234, 32'h0);          // hit
        issue(1'b1, 4'b0011, 32'h0000_1238, 32'hDEAD_BEEF); // store hit
        issue(1'b0, 4'h0, 32'h0000_1238, 32'h0);          // {A2[31:16],16'hBEEF}
        issue(1'b1, 4'hF, 32'h0000_5000, 32'h1234_5678);  // store miss, no allocate
        issue(1'b0, 4'h0, 32'h0000_5000, 32'h0);          // misses, new data
        issue(1'b0, 4'h0, 32'h0001_1230, 32'h0);          // conflicting tag
        issue(1'b0, 4'h0, 32'h0000_1230, 32'h0);          // evicted, misses again

        // Flush racing a request: flush wins, request is held off for that cycle.
        wait_idle();
        cpu_req_i = 1'b1; cpu_addr_i = 32'h0000_1230; flush_i = 1'b1;
        #1;
        check("flush_blocks_ready", cpu_ready_o, 1'b0);
        @(posedge clk);
        #1;
        flush_i = 1'b0; cpu_req_i = 1'b0; cpu_addr_i = '0;
        clear_valid();
        issue(1'b0, 4'h0, 32'h0000_1230, 32'h0);          // misses after flush

        // Reset after beat 2 of a refill; the line must not come back as a hit.
        wait_idle();
        issue(1'b0, 4'h0, 32'h0000_2344, 32'h0);
        waited = 0;
        while (!(beat_n == 3 && beats_left == 1) && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("midrefill_reached_beat2", waited < 200, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrefill_reset_outputs");
        check("midrefill_reset_state", dbg_state_o, S_IDLE);
        exp_q.delete();
        clear_valid();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 4'h0, 32'h0000_2344, 32'h0);          // must miss

        // Random mix over a few sets and tags to exercise hits, conflicts and flushes.
        for (int i = 0; i < 200; i++) begin
            int r;
            logic [31:0] a;
            logic [7:0] ix;
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 2))
                0:       ix = 8'h23;
                1:       ix = 8'h24;
                default: ix = 8'h7F;
            endcase
            a = {18'h0, 2'($urandom_range(0, 3)), ix, 2'($urandom_range(0, 3)), 2'b00};
            if (r < 5) do_flush();
            else if (r < 40) issue(1'b1, 4'($urandom_range(1, 15)), a, $urandom());
            else issue(1'b0, 4'h0, a, 32'h0);
        end

        wait_idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
